alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Parametrised successor to the team's 4-bit combinational ALU.
- Width is configurable.
- Adds a valid/ready handshake on input and output, registered results, status flags, variable-amount shifts, and a multi-cycle shift-add multiplier.
- Sits between the register-file read stage and the writeback stage.
- Back-pressure from writeback stalls the block.

Parameters:
- WIDTH, 4: operand and result width in bits; legal range is 2 or more.
- MUL_EN, 1: 1 implements the iterative multiplier for op 001. 0 makes op 001 a single-cycle op with result 0.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operands and cntl are valid
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  source 1
- b  in  WIDTH  source 2; also the shift amount
- cntl  in  3  operation select
- out_valid  out  1  result and flags are valid
- out_ready  in  1  consumer accepts the result
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- negative  out  1  result[WIDTH-1]
- carry  out  1  carry/borrow/shift-out/multiply-overflow flag (see Behaviour)
- overflow  out  1  signed overflow, add/sub only

Behaviour:
- Reset: state goes to IDLE. out_valid=0, in_ready=1, result=0, zero=0, negative=0, carry=0, overflow=0, iteration counter=0. Reset mid-multiply or mid-DONE aborts the operation; the result is discarded.
- States and transitions:
  - IDLE: in_ready=1. A transfer happens when in_valid&&in_ready; a, b and cntl are captured.
  - From IDLE: op 001 with MUL_EN=1 goes to MUL. Any other op goes to DONE.
  - MUL: in_ready=0. One shift-add step per cycle for WIDTH cycles, using an internal 2*WIDTH-bit product register. After the last step it goes to DONE.
  - DONE: out_valid=1, in_ready=0. Goes to IDLE on the cycle out_ready=1.
- Latency, with acceptance at edge T:
  - Single-cycle ops: out_valid=1 after edge T+1.
  - Multiply: out_valid=1 after edge T+WIDTH+1.
- Throughput for single-cycle ops: at most one op per 2 cycles.
- While out_valid=1 && out_ready=0, result and flags are held stable.
- in_valid while in_ready=0 is ignored; no operation is captured.
- Flags are computed from the captured operands and written together with result.
- Operations:
  - 000 pass: result=a. carry=0, overflow=0.
  - 001 mul: result = low WIDTH bits of the unsigned product. carry=1 if the upper WIDTH bits are nonzero. overflow=0.
  - 010 and: result=a&b. carry=0, overflow=0.
  - 011 or: result=a|b. carry=0, overflow=0.
  - 100 sll by b (b is treated as unsigned, full width). If b>=WIDTH: result=0 and carry = (b==WIDTH) ? a[0] : 0. Otherwise carry = the last bit shifted out, or 0 if b==0.
  - 101 sra by b. If b>=WIDTH: all bits = a[WIDTH-1] and carry=a[WIDTH-1]. Otherwise carry = the last bit shifted out, or 0 if b==0.
  - 110 add: result = a+b, wrapping. carry = carry-out. overflow = signed overflow.
  - 111 sub: result = a-b, wrapping. carry = 1 when a>=b unsigned (no borrow). overflow = signed overflow.
- Every cntl value is defined; there is no latch and no X on any output.
- MUL_EN=0: op 001 goes to DONE with result=0, zero=1 and the other flags 0.

Test Plan:
- Reset handling (WIDTH=4): assert reset mid-MUL (after op 001, a=7, b=5, accepted 2 cycles earlier) -> next cycle out_valid=0, in_ready=1, result=0, all flags 0; the aborted op never appears.
- Add/sub flags (WIDTH=4), out_ready held 1:
  - add a=7, b=1 -> after 1 cycle: result=8, negative=1, overflow=1, carry=0.
  - sub a=3, b=5 -> result=14, carry=0, overflow=0.
  - sub a=5, b=5 -> result=0, zero=1, carry=1.
- Multiply (WIDTH=4): a=7, b=5 -> out_valid exactly 5 cycles after acceptance, result=3, carry=1. Then a=3, b=4 -> result=12, carry=0.
- Shifts (WIDTH=4):
  - sll a=9, b=1 -> result=2, carry=1.
  - sra a=8, b=2 -> result=14, carry=0.
  - sra a=8, b=9 -> result=15, carry=1.
  - sll a=9, b=4 -> result=0, carry=1.
- Back-pressure: op and a=12, b=10 with out_ready=0 for 5 cycles -> result=8 held stable, out_valid=1, in_ready=0; an in_valid pulse during the stall is ignored. Raising out_ready -> in_ready=1 on the next cycle.
- Width generality (WIDTH=8): add a=200, b=100 -> result=44, carry=1, overflow=0. Multiply a=16, b=16 -> out_valid after 9 cycles, result=0, zero=1, carry=1.

Source files
------------

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshakes, registered results and flags,
// variable shifts and an iterative shift-add multiplier for op 001.
module alu_pipe #(
  parameter int unsigned WIDTH  = 4,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       cntl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_MUL  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLL  = 3'b100;
  localparam logic [2:0] OP_SRA  = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  result_d;
  logic              zero_d, negative_d, carry_d, overflow_d;
  logic              out_valid_d, in_ready_d;

  logic [WIDTH-1:0]  alu_res;
  logic              alu_c, alu_v;
  logic [WIDTH:0]    add_ext, sub_ext, sll_ext;
  logic signed [WIDTH:0] sra_ext;
  logic [WIDTH:0]    mul_sum;
  logic [PW-1:0]     mul_next;

  // Extended-width forms expose carry-out / last shifted-out bit in one place
  assign add_ext = {1'b0, a} + {1'b0, b};
  assign sub_ext = {1'b0, a} - {1'b0, b};
  assign sll_ext = {1'b0, a} << b;
  assign sra_ext = $signed({a, 1'b0}) >>> b;

  // One shift-add step: multiplier sits in the low half and drains out the bottom
  assign mul_sum  = prod_q[0] ? ({1'b0, prod_q[PW-1:WIDTH]} + {1'b0, mcand_q})
                              : {1'b0, prod_q[PW-1:WIDTH]};
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

  // Single-cycle operation result and flags
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (cntl)
      OP_PASS: alu_res = a;
      OP_MUL:  alu_res = '0;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SLL: begin
        alu_res = sll_ext[WIDTH-1:0];
        alu_c   = sll_ext[WIDTH];
      end
      OP_SRA: begin
        alu_res = sra_ext[WIDTH:1];
        alu_c   = sra_ext[0];
      end
      OP_ADD: begin
        alu_res = add_ext[WIDTH-1:0];
        alu_c   = add_ext[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_ext[WIDTH-1:0];
        alu_c   = ~sub_ext[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
      end
      default: alu_res = '0;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    result_d    = result;
    zero_d      = zero;
    negative_d  = negative;
    carry_d     = carry;
    overflow_d  = overflow;
    out_valid_d = out_valid;
    in_ready_d  = in_ready;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          in_ready_d = 1'b0;
          if (cntl == OP_MUL && MUL_EN) begin
            state_d = MUL;
            prod_d  = {{WIDTH{1'b0}}, b};
            mcand_d = a;
            cnt_d   = '0;
          end else begin
            state_d     = DONE;
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            negative_d  = alu_res[WIDTH-1];
            carry_d     = alu_c;
            overflow_d  = alu_v;
            out_valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        prod_d = mul_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d     = DONE;
          cnt_d       = '0;
          result_d    = mul_next[WIDTH-1:0];
          zero_d      = (mul_next[WIDTH-1:0] == '0);
          negative_d  = mul_next[WIDTH-1];
          carry_d     = |mul_next[PW-1:WIDTH];
          overflow_d  = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      result    <= '0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      mcand_q   <= mcand_d;
      result    <= result_d;
      zero      <= zero_d;
      negative  <= negative_d;
      carry     <= carry_d;
      overflow  <= overflow_d;
      out_valid <= out_valid_d;
      in_ready  <= in_ready_d;
    end
  end

endmodule
